instr_encoder_serializer: RTL

Sequential instruction encoder: packs a group plus decoded fields (the `ig*_dec_outputs` field set) into 16-bit instruction words and emits them one word per beat over a valid/ready stream. It feeds the instruction-memory writer and the test program loader, and is the exact inverse of the group decoders. Group 5 produces two words: the high word, then the 16-bit immediate.

---
 rtl/instr_encoder_serializer_pkg.sv | 88 ++++++++
 rtl/instr_hi_word_packer.sv | 52 +++++
 rtl/instr_encoder_serializer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/instr_encoder_serializer_pkg.sv
// ---------------------------------------------------------------------------
// pkg_instr_dec
// Definitions shared by the group decoders and the instruction encoder:
//   - instr_group: group identifier carried alongside decoded fields
//   - per-group ID prefixes and opcode field widths
//   - group 2 opcode values and the two pair-opcode predicates, so the
//     decoder and the encoder agree on one list
//   - op_fits(): whether an opcode fits in its group's opcode field
// ---------------------------------------------------------------------------
package pkg_instr_dec;

  // Groups are numbered 1..5. Codes 0, 6 and 7 are unknown groups.
  typedef enum logic [2:0] {
    INSTR_G1 = 3'd1,
    INSTR_G2 = 3'd2,
    INSTR_G3 = 3'd3,
    INSTR_G4 = 3'd4,
    INSTR_G5 = 3'd5
  } instr_group;

  // Group ID prefixes, MSB-aligned in the high word.
  localparam logic [0:0] INSTR_G1_PREFIX = 1'b0;
  localparam logic [1:0] INSTR_G2_PREFIX = 2'b10;
  localparam logic [3:0] INSTR_G3_PREFIX = 4'b1100;
  localparam logic [3:0] INSTR_G4_PREFIX = 4'b1101;
  localparam logic [5:0] INSTR_G5_PREFIX = 6'b111000;

  // Opcode field widths per group.
  localparam int INSTR_G1_OP_W = 3;
  localparam int INSTR_G2_OP_W = 6;
  localparam int INSTR_G3_OP_W = 2;
  localparam int INSTR_G4_OP_W = 4;
  localparam int INSTR_G5_OP_W = 3;

  // Word emitted for an unknown group when error checking is disabled.
  localparam logic [15:0] INSTR_UNKNOWN_WORD = 16'hF000;

  // Group 2 opcodes that take register pairs.
  localparam logic [5:0] instr_g2_op_invp  = 6'h10;
  localparam logic [5:0] instr_g2_op_negp  = 6'h11;
  localparam logic [5:0] instr_g2_op_lslp  = 6'h12;
  localparam logic [5:0] instr_g2_op_lsrp  = 6'h13;
  localparam logic [5:0] instr_g2_op_asrp  = 6'h14;
  localparam logic [5:0] instr_g2_op_rolp  = 6'h15;
  localparam logic [5:0] instr_g2_op_rorp  = 6'h16;
  localparam logic [5:0] instr_g2_op_rolcp = 6'h17;
  localparam logic [5:0] instr_g2_op_rorcp = 6'h18;
  localparam logic [5:0] instr_g2_op_cpyp  = 6'h19;
  localparam logic [5:0] instr_g2_op_swp   = 6'h1A;
  localparam logic [5:0] instr_g2_op_call  = 6'h1B;
  localparam logic [5:0] instr_g2_op_ldr   = 6'h20;
  localparam logic [5:0] instr_g2_op_str   = 6'h21;

  // ra names an even/odd register pair for these opcodes.
  function automatic logic is_g2_ra_pair_op(input logic [5:0] op);
    case (op)
      instr_g2_op_invp, instr_g2_op_negp, instr_g2_op_lslp, instr_g2_op_lsrp,
      instr_g2_op_asrp, instr_g2_op_rolp, instr_g2_op_rorp, instr_g2_op_rolcp,
      instr_g2_op_rorcp, instr_g2_op_cpyp, instr_g2_op_swp, instr_g2_op_call:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  // rb names an even/odd register pair for these opcodes.
  function automatic logic is_g2_rb_pair_op(input logic [5:0] op);
    case (op)
      instr_g2_op_cpyp, instr_g2_op_swp, instr_g2_op_ldr, instr_g2_op_str:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  // True when grp is known and op has no set bits above its field width.
  function automatic logic op_fits(input instr_group grp, input logic [5:0] op);
    case (grp)
      INSTR_G1: return op[5:INSTR_G1_OP_W] == '0;
      INSTR_G2: return 1'b1;
      INSTR_G3: return op[5:INSTR_G3_OP_W] == '0;
      INSTR_G4: return op[5:INSTR_G4_OP_W] == '0;
      INSTR_G5: return op[5:INSTR_G5_OP_W] == '0;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_hi_word_packer.sv
// ---------------------------------------------------------------------------
// instr_hi_word_packer
// Combinational packing of a group and its decoded fields into the high
// (first) instruction word. Excess input bits are truncated.
// Ports:
//   group     in  instr_group  group of the held instruction
//   opcode    in  6            opcode (low bits per group are used)
//   ra_index  in  4            ra / ra pair index
//   rb_index  in  4            rb (G2) or rbp (G3, G5)
//   rc_index  in  3            rcp (G3)
//   imm8      in  8            immediate for G1 and G4
//   hi_word   out 16           packed high word; 16'hF000 for unknown groups
// ---------------------------------------------------------------------------
module instr_hi_word_packer
  import pkg_instr_dec::*;
(
  input  instr_group  group,
  input  logic [5:0]  opcode,
  input  logic [3:0]  ra_index,
  input  logic [3:0]  rb_index,
  input  logic [2:0]  rc_index,
  input  logic [7:0]  imm8,
  output logic [15:0] hi_word
);

  logic [3:0] ra_f;
  logic [3:0] rb_f;

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    ra_f    = ra_index;
    rb_f    = rb_index;
    hi_word = INSTR_UNKNOWN_WORD;

    // Pair operands address the even register of the pair.
    if (is_g2_ra_pair_op(opcode)) ra_f = {ra_index[2:0], 1'b0};
    if (is_g2_rb_pair_op(opcode)) rb_f = {rb_index[2:0], 1'b0};

    case (group)
      INSTR_G1: hi_word = {INSTR_G1_PREFIX, opcode[2:0], ra_index, imm8};
      INSTR_G2: hi_word = {INSTR_G2_PREFIX, opcode, ra_f, rb_f};
      INSTR_G3: hi_word = {INSTR_G3_PREFIX, opcode[1:0], ra_index,
                           rb_index[2:0], rc_index};
      INSTR_G4: hi_word = {INSTR_G4_PREFIX, opcode[3:0], imm8};
      INSTR_G5: hi_word = {INSTR_G5_PREFIX, opcode[2:0], ra_index,
                           rb_index[2:0]};
      default:  hi_word = INSTR_UNKNOWN_WORD;
    endcase
  end

endmodule

// File: rtl/instr_encoder_serializer.sv
// ---------------------------------------------------------------------------
// instr_encoder_serializer
// Packs a group plus decoded fields into 16-bit instruction words and emits
// them one word per beat over a valid/ready stream. G5 emits two words: the
// high word, then the 16-bit immediate. Accepted fields are captured in hold
// registers; outputs depend only on those registers and the FSM state.
//
// Optional build macro: INSTR_ENC_ERR_CHECK_EN
//   defined   - unknown groups and oversize opcodes are consumed without
//               emitting a word, and err_pulse fires the cycle after accept
//   undefined - unknown groups emit 16'hF000, oversize opcodes truncate,
//               and err_pulse does not exist
//
// Ports:
//   clk, reset_n           clock (rising edge), async active-low reset
//   in_valid / in_ready    request handshake
//   in_group .. in_imm     request fields
//   out_valid / out_ready  word handshake
//   out_word               instruction word
//   out_first / out_last   word is first / last of its instruction
//   err_pulse              one-cycle error flag (macro builds only)
// ---------------------------------------------------------------------------
module instr_encoder_serializer
  import pkg_instr_dec::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  instr_group  in_group,
  input  logic [5:0]  in_opcode,
  input  logic [3:0]  in_ra_index,
  input  logic [3:0]  in_rb_index,
  input  logic [2:0]  in_rc_index,
  input  logic [15:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic        out_first,
  output logic        out_last
`ifdef INSTR_ENC_ERR_CHECK_EN
  ,
  output logic        err_pulse
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } enc_state_e;

  enc_state_e  state;
  instr_group  hold_grp;
  logic [5:0]  hold_op;
  logic [3:0]  hold_ra;
  logic [3:0]  hold_rb;
  logic [2:0]  hold_rc;
  logic [15:0] hold_imm;
  logic [15:0] hi_word;

  logic accept;     // request handshake this cycle
  logic flagged;    // accepted request is malformed (macro builds only)
  logic accept_ok;  // accepted request that will emit words
  logic out_fire;   // word handshake this cycle

  instr_hi_word_packer u_packer (
    .group    (hold_grp),
    .opcode   (hold_op),
    .ra_index (hold_ra),
    .rb_index (hold_rb),
    .rc_index (hold_rc),
    .imm8     (hold_imm[7:0]),
    .hi_word  (hi_word)
  );

  // Output decode from state and hold registers only.
  assign out_valid = (state != S_IDLE);
  assign out_first = (state == S_HI);
  assign out_last  = ((state == S_HI) && (hold_grp != INSTR_G5)) ||
                     (state == S_LO);
  assign out_word  = (state == S_HI) ? hi_word  :
                     (state == S_LO) ? hold_imm : 16'h0000;

  assign out_fire  = out_valid && out_ready;
  // A new request may enter as the last word of the current one leaves.
  assign in_ready  = (state == S_IDLE) || (out_fire && out_last);
  assign accept    = in_valid && in_ready;

`ifdef INSTR_ENC_ERR_CHECK_EN
  assign flagged   = !op_fits(in_group, in_opcode);
`else
  assign flagged   = 1'b0;
`endif
  assign accept_ok = accept && !flagged;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      // NOTE: the hold registers are reset too, so the datapath never
      // carries X into the packer even though IDLE masks out_word.
      hold_grp <= INSTR_G1;
      hold_op  <= '0;
      hold_ra  <= '0;
      hold_rb  <= '0;
      hold_rc  <= '0;
      hold_imm <= '0;
    end else begin
      if (accept) begin
        hold_grp <= in_group;
        hold_op  <= in_opcode;
        hold_ra  <= in_ra_index;
        hold_rb  <= in_rb_index;
        hold_rc  <= in_rc_index;
        hold_imm <= in_imm;
      end

      case (state)
        S_IDLE: if (accept_ok) state <= S_HI;
        S_HI: begin
          if (out_fire) begin
            if (hold_grp == INSTR_G5) state <= S_LO;
            else                      state <= accept_ok ? S_HI : S_IDLE;
          end
        end
        S_LO: if (out_fire) state <= accept_ok ? S_HI : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef INSTR_ENC_ERR_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_pulse <= 1'b0;
    else          err_pulse <= accept && flagged;
  end
`endif

endmodule
